fetch_decode_unit: RTL and testbench

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

---
 rtl/fetch_decode_unit.sv | 127 ++++++++++++
 tb/tb_fetch_decode_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_unit.sv
// Instruction fetch and IF/ID decode stage: PC sequencing, branch redirect,
// load-use bubble insertion and main control decode for a MIPS-style pipeline.
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        Branch,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [4:0]  read0,
    output logic [4:0]  read1,
    output logic [1:0]  WBID,
    output logic [2:0]  MEID,
    output logic [3:0]  EXID,
    output logic        stall
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HAZARD   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    state_t      state, state_nx;
    logic [31:0] pc;
    logic [31:0] ifid;
    logic [4:0]  loaded_rt;
    logic        loaded_vld;

    logic [5:0]  opcode;
    logic [1:0]  wb_dec;
    logic [2:0]  me_dec;
    logic [3:0]  ex_dec;
    logic        uses_rt;
    logic        hazard;

    assign opcode    = ifid[31:26];
    assign imem_addr = pc;
    assign instr     = ifid;
    assign read0     = ifid[25:21];
    assign read1     = ifid[20:16];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wb_dec  = 2'b00;
        me_dec  = 3'b000;
        ex_dec  = 4'b0000;
        uses_rt = 1'b0;
        case (opcode)
            6'h00: begin wb_dec = 2'b11; ex_dec = 4'b0100; uses_rt = 1'b1; end
            6'h23: begin wb_dec = 2'b10; me_dec = 3'b010; ex_dec = 4'b1001; end
            6'h2B: begin me_dec = 3'b001; ex_dec = 4'b1001; uses_rt = 1'b1; end
            6'h04: begin me_dec = 3'b100; ex_dec = 4'b0010; uses_rt = 1'b1; end
            6'h08: begin wb_dec = 2'b11; ex_dec = 4'b1001; end
            default: ;
        endcase
        // The all-zero word is the pipeline NOP: R-type with the register write suppressed.
        if (ifid == NOP) wb_dec = 2'b00;
    end

    // Only RUN can see a live hazard; HAZARD and REDIRECT follow a cycle whose controls were killed.
    always_comb begin
        hazard = (state == RUN) && loaded_vld && (loaded_rt != 5'd0) &&
                 ((read0 == loaded_rt) || (uses_rt && (read1 == loaded_rt)));
    end

    always_comb begin
        state_nx = RUN;
        stall    = 1'b0;
        WBID     = wb_dec;
        MEID     = me_dec;
        EXID     = ex_dec;
        if (rst) begin
            WBID = 2'b00;
            MEID = 3'b000;
            EXID = 4'b0000;
        end else if (Branch) begin
            state_nx = REDIRECT;
            WBID     = 2'b00;
            MEID     = 3'b000;
            EXID     = 4'b0000;
        end else if (hazard) begin
            state_nx = HAZARD;
            stall    = 1'b1;
            WBID     = 2'b00;
            MEID     = 3'b000;
            EXID     = 4'b0000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid       <= NOP;
            loaded_rt  <= 5'd0;
            loaded_vld <= 1'b0;
        end else begin
            // Killed controls (branch flush or bubble) clear the load tracker naturally.
            loaded_vld <= MEID[1];
            loaded_rt  <= read1;
            if (Branch) begin
                pc   <= {branch_target[31:2], 2'b00};
                ifid <= NOP;
            end else if (!stall) begin
                if (imem_valid) begin
                    pc   <= pc + 32'd4;
                    ifid <= imem_data;
                end else begin
                    ifid <= NOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed scenarios plus a randomized
// stream, all compared against an instruction-level reference model.
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_data, branch_target, instr;
    logic        imem_valid, Branch, stall;
    logic [4:0]  read0, read1;
    logic [1:0]  WBID;
    logic [2:0]  MEID;
    logic [3:0]  EXID;

    logic [31:0] addr2, data2, instr2;
    logic [4:0]  r0_2, r1_2;
    logic [1:0]  wb2;
    logic [2:0]  me2;
    logic [3:0]  ex2;
    logic        stall2;

    logic [31:0] mem [64];
    logic [83:0] got, got2, expv;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] m_pc, m_ir;
    logic        m_ld;
    logic [4:0]  m_rt;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:2]];
    assign data2     = mem[addr2[7:2]];
    assign got  = {imem_addr, instr, read0, read1, WBID, MEID, EXID, stall};
    assign got2 = {addr2, instr2, r0_2, r1_2, wb2, me2, ex2, stall2};

    fetch_decode_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_valid(imem_valid), .Branch(Branch), .branch_target(branch_target),
        .instr(instr), .read0(read0), .read1(read1), .WBID(WBID), .MEID(MEID),
        .EXID(EXID), .stall(stall)
    );

    fetch_decode_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_addr(addr2), .imem_data(data2),
        .imem_valid(imem_valid), .Branch(Branch), .branch_target(branch_target),
        .instr(instr2), .read0(r0_2), .read1(r1_2), .WBID(wb2), .MEID(me2),
        .EXID(ex2), .stall(stall2)
    );

    // ---------------- reference model (one instruction slot, no pipeline states) ----------------
    function automatic logic [8:0] ref_ctrl(input logic [31:0] ir);
        if (ir == 32'h0) return 9'b00_000_0100;
        case (ir[31:26])
            6'h00:   return 9'b11_000_0100;
            6'h23:   return 9'b10_010_1001;
            6'h2B:   return 9'b00_001_1001;
            6'h04:   return 9'b00_100_0010;
            6'h08:   return 9'b11_000_1001;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic ref_hazard(input logic [31:0] ir, input logic ld, input logic [4:0] rt);
        logic reads_rt;
        reads_rt = (ir[31:26] == 6'h00) || (ir[31:26] == 6'h2B) || (ir[31:26] == 6'h04);
        return ld && (rt != 5'd0) && ((ir[25:21] == rt) || (reads_rt && ir[20:16] == rt));
    endfunction

    function automatic logic [83:0] ref_out();
        logic [8:0] c;
        if (rst) return {32'h0, 52'h0};
        c = ref_ctrl(m_ir);
        if (Branch)                       return {m_pc, m_ir, m_ir[25:21], m_ir[20:16], 9'b0, 1'b0};
        if (ref_hazard(m_ir, m_ld, m_rt)) return {m_pc, m_ir, m_ir[25:21], m_ir[20:16], 9'b0, 1'b1};
        return {m_pc, m_ir, m_ir[25:21], m_ir[20:16], c, 1'b0};
    endfunction

    task automatic ref_step();
        logic hz;
        if (rst) return;
        hz = ref_hazard(m_ir, m_ld, m_rt);
        if (Branch) begin
            m_pc = {branch_target[31:2], 2'b00};
            m_ir = 32'h0;
            m_ld = 1'b0;
        end else if (hz) begin
            m_ld = 1'b0;
        end else begin
            m_ld = (m_ir[31:26] == 6'h23);
            m_rt = m_ir[20:16];
            if (imem_valid) begin
                m_ir = mem[m_pc[7:2]];
                m_pc = m_pc + 32'd4;
            end else begin
                m_ir = 32'h0;
            end
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_ld = 1'b0; m_rt = 5'd0;
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic drive(input logic b, input logic [31:0] t, input logic v);
        Branch = b; branch_target = t; imem_valid = v;
        #1;
        expv = ref_out();
    endtask

    task automatic advance();
        ref_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; Branch = 1'b0; branch_target = 32'h0; imem_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_addi();
        for (int i = 0; i < 64; i++) mem[i] = 32'h2001_0005;
    endtask

    task automatic load_use_program();
        fill_addi();
        mem[0] = 32'h8C02_0000;   // lw  $2, 0($0)
        mem[1] = 32'h0042_1820;   // add $3, $2, $2
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        fill_addi();
        apply_reset();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1); advance(); end
        @(posedge clk); #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (got !== 84'h0) begin failures++; $display("FAIL reset_async got=%h expected=0", got); end
        checks++;
        if (got2 !== {32'hFFFF_FFFC, 52'h0}) begin failures++; $display("FAIL reset_pc2 got=%h", got2); end
        @(posedge clk); #1;
        checks++;
        if (got !== 84'h0) begin failures++; $display("FAIL reset_held got=%h expected=0", got); end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 1);
        checks++;
        if (got !== expv) begin failures++; $display("FAIL reset_release got=%h expected=%h", got, expv); end
        advance();
    endtask

    task automatic test_stream();
        fill_addi();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL stream c%0d got=%h expected=%h", i, got, expv); end
            if (i < 3) begin
                checks++;
                if (imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr c%0d got=%h expected=%h", i, imem_addr, 4 * i); end
            end
            if (i == 1) begin
                checks++;
                if ({instr, WBID, EXID} !== {32'h2001_0005, 2'b11, 4'b1001}) begin
                    failures++; $display("FAIL stream_decode got=%h/%b/%b", instr, WBID, EXID);
                end
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        load_use_program();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL load_use c%0d got=%h expected=%h", i, got, expv); end
            if (stall) stalls++;
            if (i == 2) begin
                checks++;
                if ({stall, imem_addr, WBID, MEID, EXID} !== {1'b1, 32'h8, 9'b0}) begin
                    failures++; $display("FAIL load_use_bubble got=%b addr=%h", stall, imem_addr);
                end
            end
            if (i == 3) begin
                checks++;
                if ({imem_addr, instr, WBID, EXID} !== {32'h8, 32'h0042_1820, 2'b11, 4'b0100}) begin
                    failures++; $display("FAIL load_use_redecode got=%h %h %b %b", imem_addr, instr, WBID, EXID);
                end
            end
            advance();
        end
        checks++;
        if (stalls != 1) begin failures++; $display("FAIL load_use_count got=%0d expected=1", stalls); end
    endtask

    task automatic test_branch();
        load_use_program();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i == 2, 32'h0000_0041, 1);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL branch c%0d got=%h expected=%h", i, got, expv); end
            if (i == 2) begin
                checks++;
                if ({stall, WBID, MEID, EXID} !== 10'b0) begin failures++; $display("FAIL branch_kill got=%b", {stall, WBID, MEID, EXID}); end
            end
            if (i == 3) begin
                checks++;
                if ({imem_addr, instr, stall} !== {32'h40, 32'h0, 1'b0}) begin
                    failures++; $display("FAIL branch_redirect got=%h %h %b", imem_addr, instr, stall);
                end
            end
            if (i > 3) begin
                checks++;
                if (stall !== 1'b0) begin failures++; $display("FAIL branch_no_bubble c%0d got=%b expected=0", i, stall); end
            end
            advance();
        end
    endtask

    task automatic test_invalid();
        logic [31:0] held = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h2001_0000 | 32'(i);
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, !(i >= 2 && i <= 4));
            checks++;
            if (got !== expv) begin failures++; $display("FAIL invalid c%0d got=%h expected=%h", i, got, expv); end
            if (i == 2) held = imem_addr;
            if (i >= 3 && i <= 5) begin
                checks++;
                if ({imem_addr, instr} !== {held, 32'h0}) begin
                    failures++; $display("FAIL invalid_hold c%0d got=%h %h expected=%h 0", i, imem_addr, instr, held);
                end
            end
            if (i == 6) begin
                checks++;
                if (instr !== (32'h2001_0000 | (held >> 2))) begin
                    failures++; $display("FAIL invalid_resume got=%h held_addr=%h", instr, held);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        fill_addi();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i == 2, 32'hFFFF_FFFB, 1);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL wrap c%0d got=%h expected=%h", i, got, expv); end
            if (i == 0) begin
                checks++;
                if (got2 !== {32'hFFFF_FFFC, 32'h0, 5'd0, 5'd0, 9'b00_000_0100, 1'b0}) begin
                    failures++; $display("FAIL wrap_reset_pc got=%h", got2);
                end
            end
            if (i == 1) begin
                checks++;
                if (got2 !== {32'h0, 32'h2001_0005, 5'd0, 5'd1, 9'b11_000_1001, 1'b0}) begin
                    failures++; $display("FAIL wrap_rollover got=%h", got2);
                end
            end
            if (i == 5) begin
                checks++;
                if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_branch got=%h expected=0", imem_addr); end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        load_use_program();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL async c%0d got=%h expected=%h", i, got, expv); end
            if (i < 2) advance();
        end
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL async_pre_stall got=%b expected=1", stall); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (got !== 84'h0) begin failures++; $display("FAIL async_reset_zero got=%h expected=0", got); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL async_after c%0d got=%h expected=%h", i, got, expv); end
            checks++;
            if ({imem_addr, stall} !== {32'(4 * i), 1'b0}) begin
                failures++; $display("FAIL async_refetch c%0d got=%h/%b expected=%h/0", i, imem_addr, stall, 4 * i);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F, 6'h00};
        int k;
        for (int i = 0; i < 64; i++) begin
            k = int'($urandom_range(0, 6));
            mem[i] = {ops[k], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            if (k == 6) mem[i] = 32'h0;
        end
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) != 0);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL random c%0d got=%h expected=%h", i, got, expv); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; Branch = 1'b0; branch_target = 32'h0; imem_valid = 1'b0;
        fill_addi();
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_load_use();
        test_branch();
        test_invalid();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
